sar_ctrl_param: RTL and testbench
=================================

Name: sar_ctrl_param

Overview:
- Parametrised, handshake-driven successor to the fixed 10-bit SAR controller.
- Generates the sample clocks (CLKS/CLKSB) and runs an NBITS-bit successive-approximation sequence, MSB first, into the P/N CDAC switch registers.
- Latches the final code and emits a single-cycle EOC.
- Supports single-shot (START-triggered) and continuous (free-running) modes; sits between the comparator and the digital readout.

Parameters:
- NBITS, 10, conversion resolution in bits (legal 2..16).
- SAMP_CYCLES, 16, CLK_S cycles CLKS is held high per sample phase (legal 1..256).
- CNT_W, 8, width of the internal phase counter; must hold max(SAMP_CYCLES, NBITS)-1.

Ports:
- CLK_S  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- START  input  1  single-shot conversion request, sampled in IDLE/DONE
- CONT  input  1  1 = continuous mode, auto-restart after DONE
- COMP_P  input  1  comparator positive decision
- COMP_N  input  1  comparator negative decision
- CLKS  output  1  sample switch control, 1 during SAMPLE
- CLKSB  output  1  complement of CLKS
- BUSY  output  1  high in SAMPLE, CONVERT and DONE
- CF  output  NBITS  thermometer of resolved bits, bit i set once bit i is decided
- CDAC_P  output  NBITS  P-side CDAC switch bits
- CDAC_N  output  NBITS  N-side CDAC switch bits
- DOUT  output  NBITS  last completed conversion code
- EOC  output  1  one-cycle pulse, DOUT updated

Behaviour:
- Reset (RST=1 at an edge):
  - State goes to IDLE; counter=0.
  - CLKS=0, CLKSB=1, BUSY=0, EOC=0; CF, CDAC_P, CDAC_N, DOUT all 0.
  - RST mid-operation aborts immediately. DOUT is cleared and no EOC is issued.
- FSM states: IDLE, SAMPLE, CONVERT, DONE.
- IDLE:
  - If START or CONT at an edge: go to SAMPLE, clear CDAC_P/N and CF, counter=0.
  - Otherwise remain in IDLE; outputs are held.
- SAMPLE:
  - CLKS=1, CLKSB=0 for exactly SAMP_CYCLES cycles; counter increments each cycle.
  - When counter==SAMP_CYCLES-1: go to CONVERT, counter=0, CLKS=0, CLKSB=1.
- CONVERT:
  - Exactly NBITS cycles. In cycle k (k=0..NBITS-1), bit i=NBITS-1-k is resolved.
  - At the edge ending cycle k: CDAC_P[i]<=COMP_P, CDAC_N[i]<=COMP_N, CF[i]<=1.
  - At the edge ending k=NBITS-1: DOUT<=final CDAC_P value including bit 0 (from the same edge's COMP_P), EOC<=1, go to DONE.
- DONE:
  - Lasts 1 cycle; EOC=1 only in this cycle.
  - Next edge: go to SAMPLE if CONT or START, else go to IDLE. CDAC_P/N and CF are held until the next SAMPLE entry.
- Latency: with START high at edge t (IDLE):
  - SAMPLE occupies cycles t+1..t+SAMP_CYCLES.
  - CONVERT occupies the next NBITS cycles.
  - EOC is high in cycle t+SAMP_CYCLES+NBITS+1.
  - Continuous-mode period is SAMP_CYCLES+NBITS+1 cycles.
- START handling:
  - START is ignored in SAMPLE and CONVERT (no queuing).
  - START held high in DONE behaves like CONT for that one transition.
- CONT deasserted mid-conversion: the current conversion completes, then the FSM returns to IDLE.
- COMP_P=COMP_N: bits are stored as-is, with no correction.
- Counter never wraps past its terminal value in either phase.

Optional Feature:
- Macro: SAR_COMP_ERR_EN
- When defined:
  - Adds output port ERR (1 bit), cleared at SAMPLE entry and on RST.
  - ERR is set sticky if COMP_P==COMP_N at any CONVERT decision edge.
  - ERR is valid alongside EOC and held until the next SAMPLE entry.
  - The affected bit is forced to CDAC_P[i]=0, CDAC_N[i]=1.
- When undefined: the ERR port is absent and no forcing occurs.

Test Plan (NBITS=10, SAMP_CYCLES=4 unless noted):
- Reset: hold RST 3 cycles, then release -> CLKS=0, CLKSB=1, DOUT=0, CF=0, BUSY=0, no EOC.
- Single shot: START pulse at edge t; drive COMP_P MSB-first 1010100101 with COMP_N=~COMP_P -> CLKS high cycles t+1..t+4; EOC exactly at t+15; DOUT=0x2A5; CDAC_N=0x15A; CF=0x3FF.
- Continuous mode: CONT=1 for 3 conversions -> EOC every 15 cycles. DOUT sequence matches the per-conversion comparator patterns (0x000, 0x3FF, 0x155).
- Abort: RST asserted in the 3rd CONVERT cycle -> next cycle IDLE, DOUT=0, no EOC. A subsequent START produces a normal conversion.
- START ignored: START pulses during SAMPLE and CONVERT -> exactly one EOC per accepted START. START held in DONE -> back-to-back conversion.
- SAR_COMP_ERR_EN (NBITS=4, SAMP_CYCLES=1): COMP_P=COMP_N=1 on bit 2 -> ERR=1 at EOC, CDAC_P[2]=0, CDAC_N[2]=1. Next conversion with clean comparator -> ERR=0.

Source files
------------

// File: rtl/sar_ctrl_param_if.sv
// Handshake/bus bundle for the parametrised SAR controller.
// The slave modport is the controller; the master modport is whoever owns
// the conversion request and comparator (system logic or a bench).
// Optional SAR_COMP_ERR_EN adds the comparator-error flag ERR.
interface sar_ctrl_param_if #(
  parameter int NBITS = 10
);
  logic             START;
  logic             CONT;
  logic             COMP_P;
  logic             COMP_N;
  logic             CLKS;
  logic             CLKSB;
  logic             BUSY;
  logic             EOC;
  logic [NBITS-1:0] CF;
  logic [NBITS-1:0] CDAC_P;
  logic [NBITS-1:0] CDAC_N;
  logic [NBITS-1:0] DOUT;
`ifdef SAR_COMP_ERR_EN
  logic             ERR;

  modport master (
    output START, CONT, COMP_P, COMP_N,
    input  CLKS, CLKSB, BUSY, EOC, CF, CDAC_P, CDAC_N, DOUT, ERR
  );
  modport slave (
    input  START, CONT, COMP_P, COMP_N,
    output CLKS, CLKSB, BUSY, EOC, CF, CDAC_P, CDAC_N, DOUT, ERR
  );
`else
  modport master (
    output START, CONT, COMP_P, COMP_N,
    input  CLKS, CLKSB, BUSY, EOC, CF, CDAC_P, CDAC_N, DOUT
  );
  modport slave (
    input  START, CONT, COMP_P, COMP_N,
    output CLKS, CLKSB, BUSY, EOC, CF, CDAC_P, CDAC_N, DOUT
  );
`endif
endinterface

// File: rtl/sar_ctrl_param.sv
// Parametrised SAR controller: sample-clock generation, NBITS-bit
// MSB-first successive approximation into P/N CDAC switch registers,
// final-code latch and single-cycle EOC. Single-shot (START) and
// continuous (CONT) modes.
// Optional build macro SAR_COMP_ERR_EN: adds sticky ERR flag and forces a
// bit to P=0/N=1 when the comparator outputs agree at a decision edge.

// One CDAC bit slice: switch pair plus its "resolved" flag.
module sar_ctrl_param_bit (
  input  logic CLK_S,
  input  logic RST,
  input  logic clr,     // new sample phase starting
  input  logic res,     // this bit is decided at this edge
  input  logic comp_p,
  input  logic comp_n,
  output logic cf,
  output logic p,
  output logic n,
  output logic p_nxt    // value p takes at this edge, for the DOUT latch
);
  logic dp, dn;

  // Decision mapping; with the error option an ambiguous comparator
  // result resolves the bit downward.
  always_comb begin
    dp = comp_p;
    dn = comp_n;
`ifdef SAR_COMP_ERR_EN
    if (comp_p == comp_n) begin
      dp = 1'b0;
      dn = 1'b1;
    end
`endif
  end

  assign p_nxt = res ? dp : p;

  // Switch registers: cleared on reset/sample entry, loaded when selected.
  always_ff @(posedge CLK_S) begin
    if (RST || clr) begin
      cf <= 1'b0;
      p  <= 1'b0;
      n  <= 1'b0;
    end else if (res) begin
      cf <= 1'b1;
      p  <= dp;
      n  <= dn;
    end
  end
endmodule

module sar_ctrl_param #(
  parameter int NBITS       = 10,
  parameter int SAMP_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             CLK_S,
  input  logic             RST,
  sar_ctrl_param_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SAMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(NBITS - 1);
  localparam logic [NBITS-1:0] MSB_ONE   = {1'b1, {(NBITS-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             clks, clksb, busy, eoc;
  logic [NBITS-1:0] dout;
  logic [NBITS-1:0] cf, cdac_p, cdac_n, p_nxt;
  logic [NBITS-1:0] bit_sel, res;
  logic             samp_go;

  // A new conversion starts from IDLE or straight out of DONE.
  assign samp_go = ((state == IDLE) || (state == DONE)) && (bus.START || bus.CONT);

  // Cycle k of CONVERT resolves bit NBITS-1-k; cnt never exceeds NBITS-1 here.
  assign bit_sel = MSB_ONE >> cnt;
  assign res     = (state == CONVERT) ? bit_sel : '0;

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    sar_ctrl_param_bit u_bit (
      .CLK_S  (CLK_S),
      .RST    (RST),
      .clr    (samp_go),
      .res    (res[i]),
      .comp_p (bus.COMP_P),
      .comp_n (bus.COMP_N),
      .cf     (cf[i]),
      .p      (cdac_p[i]),
      .n      (cdac_n[i]),
      .p_nxt  (p_nxt[i])
    );
  end

  // Phase sequencer with registered sample clocks, BUSY, EOC and code latch.
  always_ff @(posedge CLK_S) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      clks  <= 1'b0;
      clksb <= 1'b1;
      busy  <= 1'b0;
      eoc   <= 1'b0;
      dout  <= '0;
    end else begin
      eoc <= 1'b0;
      if (samp_go) begin
        state <= SAMPLE;
        cnt   <= '0;
        clks  <= 1'b1;
        clksb <= 1'b0;
        busy  <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          SAMPLE: begin
            if (cnt == SAMP_LAST) begin
              state <= CONVERT;
              cnt   <= '0;
              clks  <= 1'b0;
              clksb <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          CONVERT: begin
            if (cnt == CONV_LAST) begin
              state <= DONE;
              cnt   <= '0;
              dout  <= p_nxt;
              eoc   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SAR_COMP_ERR_EN
  logic err;

  // Sticky flag for ambiguous comparator decisions within one conversion.
  always_ff @(posedge CLK_S) begin
    if (RST || samp_go)
      err <= 1'b0;
    else if ((state == CONVERT) && (bus.COMP_P == bus.COMP_N))
      err <= 1'b1;
  end

  assign bus.ERR = err;
`endif

  assign bus.CLKS   = clks;
  assign bus.CLKSB  = clksb;
  assign bus.BUSY   = busy;
  assign bus.EOC    = eoc;
  assign bus.CF     = cf;
  assign bus.CDAC_P = cdac_p;
  assign bus.CDAC_N = cdac_n;
  assign bus.DOUT   = dout;
endmodule

// File: tb/tb_sar_ctrl_param.sv
// Scoreboard bench for sar_ctrl_param. Stimulus pushes the expected EOC
// cycle and code; a negedge monitor pops on every EOC.
// Default build: NBITS=10, SAMP_CYCLES=4. With SAR_COMP_ERR_EN: NBITS=4,
// SAMP_CYCLES=1 and the comparator-error sequence.
`timescale 1ns/1ps
module tb_sar_ctrl_param;
`ifdef SAR_COMP_ERR_EN
  localparam int NB = 4;
  localparam int SC = 1;
`else
  localparam int NB = 10;
  localparam int SC = 4;
`endif

  typedef struct {
    int             cyc;
    logic [NB-1:0]  code;
    logic [NB-1:0]  n;
    logic [NB-1:0]  cf;
    logic           err;
  } exp_t;

  logic CLK_S = 1'b0;
  logic RST   = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  exp_t e;

  always #5 CLK_S = ~CLK_S;
  always @(posedge CLK_S) cyc <= cyc + 1;

  sar_ctrl_param_if #(.NBITS(NB)) bus ();

  sar_ctrl_param #(.NBITS(NB), .SAMP_CYCLES(SC), .CNT_W(8)) dut (
    .CLK_S (CLK_S),
    .RST   (RST),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK_S);
    #1;
  endtask

  task automatic expect_eoc(input int c, input logic [NB-1:0] p, input logic [NB-1:0] n,
                            input logic err);
    q.push_back('{c, p, n, {NB{1'b1}}, err});
  endtask

  // Entered in CONVERT cycle 0; leaves in the DONE cycle.
  task automatic drive_bits(input logic [NB-1:0] p, input logic [NB-1:0] n, input int start_k);
    for (int k = 0; k < NB; k++) begin
      bus.COMP_P = p[NB-1-k];
      bus.COMP_N = n[NB-1-k];
      bus.START  = (k == start_k);
      tick();
    end
    bus.START = 1'b0;
  endtask

  // Monitor: every EOC must match the oldest pending expectation.
  always @(negedge CLK_S) begin
    if (mon_en && bus.EOC !== 1'b0) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_eoc: EOC=%b at cycle %0d, want no EOC", bus.EOC, cyc);
      end else begin
        e = q.pop_front();
        chk("eoc_cycle", cyc, e.cyc);
        chk("dout", bus.DOUT, e.code);
        chk("cdac_p", bus.CDAC_P, e.code);
        chk("cdac_n", bus.CDAC_N, e.n);
        chk("cf", bus.CF, e.cf);
        chk("busy_done", bus.BUSY, 1);
`ifdef SAR_COMP_ERR_EN
        chk("err", bus.ERR, e.err);
`endif
      end
    end
  end

  initial begin
    int c0;
    logic [NB-1:0] pat;
    logic [NB-1:0] pats [3];
    bus.START  = 1'b0;
    bus.CONT   = 1'b0;
    bus.COMP_P = 1'b0;
    bus.COMP_N = 1'b0;

    // Reset held 3 cycles
    RST = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
    chk("rst_clks", bus.CLKS, 0);
    chk("rst_clksb", bus.CLKSB, 1);
    chk("rst_dout", bus.DOUT, 0);
    chk("rst_cf", bus.CF, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_cdac_p", bus.CDAC_P, 0);
    chk("rst_cdac_n", bus.CDAC_N, 0);
`ifdef SAR_COMP_ERR_EN
    chk("rst_err", bus.ERR, 0);

    // Bit 2 ambiguous (P=N=1): forced to P=0/N=1, ERR set
    c0 = cyc;
    bus.START = 1'b1;
    expect_eoc(c0 + 1 + SC + NB, 4'h9, 4'h6, 1'b1);
    tick();
    bus.START = 1'b0;
    repeat (SC) tick();
    drive_bits(4'b1101, 4'b0110, -1);
    tick();
    chk("err_hold_idle", bus.ERR, 1);

    // Clean conversion clears ERR
    c0 = cyc;
    bus.START = 1'b1;
    expect_eoc(c0 + 1 + SC + NB, 4'h3, 4'hC, 1'b0);
    tick();
    bus.START = 1'b0;
    chk("err_clr_sample", bus.ERR, 0);
    repeat (SC) tick();
    drive_bits(4'b0011, 4'b1100, -1);
    tick();
`else
    // Single shot: 0x2A5, COMP_N complementary
    pat = 10'h2A5;
    c0 = cyc;
    bus.START = 1'b1;
    expect_eoc(c0 + 1 + SC + NB, pat, ~pat, 1'b0);
    tick();
    bus.START = 1'b0;
    for (int s = 0; s < SC; s++) begin
      chk("samp_clks", bus.CLKS, 1);
      chk("samp_clksb", bus.CLKSB, 0);
      tick();
    end
    chk("conv_clks", bus.CLKS, 0);
    chk("conv_clksb", bus.CLKSB, 1);
    chk("conv_busy", bus.BUSY, 1);
    drive_bits(pat, ~pat, -1);
    tick();
    chk("idle_busy", bus.BUSY, 0);
    chk("idle_dout_hold", bus.DOUT, 10'h2A5);

    // Continuous: three conversions, CONT dropped during the third
    pats[0] = 10'h000;
    pats[1] = 10'h3FF;
    pats[2] = 10'h155;
    c0 = cyc;
    bus.CONT = 1'b1;
    for (int j = 0; j < 3; j++)
      expect_eoc(c0 + 1 + SC + NB + j * (SC + NB + 1), pats[j], ~pats[j], 1'b0);
    tick();
    for (int j = 0; j < 3; j++) begin
      repeat (SC) tick();
      if (j == 2) bus.CONT = 1'b0;
      drive_bits(pats[j], ~pats[j], -1);
      tick();
    end
    chk("cont_stop_busy", bus.BUSY, 0);
    chk("cont_stop_clks", bus.CLKS, 0);

    // Abort by reset in the 3rd CONVERT cycle
    c0 = cyc;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    repeat (SC) tick();
    bus.COMP_P = 1'b1;
    bus.COMP_N = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    chk("abort_busy", bus.BUSY, 0);
    chk("abort_dout", bus.DOUT, 0);
    chk("abort_cf", bus.CF, 0);
    chk("abort_cdac_p", bus.CDAC_P, 0);
    chk("abort_clksb", bus.CLKSB, 1);
    RST = 1'b0;
    tick();

    // Normal conversion after abort, COMP_N equal to COMP_P (stored as-is)
    pat = 10'h0F3;
    c0 = cyc;
    bus.START = 1'b1;
    expect_eoc(c0 + 1 + SC + NB, pat, pat, 1'b0);
    tick();
    bus.START = 1'b0;
    repeat (SC) tick();
    drive_bits(pat, pat, -1);
    tick();

    // START pulses in SAMPLE and CONVERT ignored; START in DONE chains
    pat = 10'h3C1;
    c0 = cyc;
    bus.START = 1'b1;
    expect_eoc(c0 + 1 + SC + NB, pat, ~pat, 1'b0);
    tick();
    tick();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    repeat (SC - 2) tick();
    drive_bits(pat, ~pat, 5);
    pat = 10'h081;
    bus.START = 1'b1;
    expect_eoc(cyc + 1 + SC + NB, pat, ~pat, 1'b0);
    tick();
    bus.START = 1'b0;
    chk("chain_clks", bus.CLKS, 1);
    repeat (SC) tick();
    drive_bits(pat, ~pat, -1);
    tick();
    chk("chain_idle_busy", bus.BUSY, 0);
`endif

    repeat (5) tick();
    chk("pending_eoc", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
